// File: rtl/vga_timing_gen.sv
// Raster timing source: free-running h/v counters with registered sync, video window and
// frame/line markers, all decoded from the next-count values so they align with pixel_x/y.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic        line_end,
  output logic [15:0] frame_count
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (HTotal > 1024) begin : g_h_too_long
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (VTotal > 1024) begin : g_v_too_long
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  // 11-bit constants so an end bound of exactly 1024 still compares correctly.
  localparam logic [10:0] HLast      = 11'(HTotal - 1);
  localparam logic [10:0] VLast      = 11'(VTotal - 1);
  localparam logic [10:0] HVis       = 11'(H_VISIBLE);
  localparam logic [10:0] VVis       = 11'(V_VISIBLE);
  localparam logic [10:0] HSyncStart = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HSyncEnd   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncStart = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VSyncEnd   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [15:0] fc_q, fc_d;
  logic        run_q, run_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic        vo_q, vo_d, fs_q, fs_d, le_q, le_d;
  logic [10:0] hx, vx;

  assign hx = {1'b0, h_d};
  assign vx = {1'b0, v_d};

  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    fc_d  = fc_q;
    run_d = run_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    vo_d  = 1'b0;
    fs_d  = 1'b0;
    le_d  = 1'b0;
    if (enable) begin
      run_d = 1'b1;
      // The first enabled edge after reset presents (0,0) rather than advancing past it.
      if (run_q) begin
        if ({1'b0, h_q} == HLast) begin
          h_d = '0;
          if ({1'b0, v_q} == VLast) begin
            v_d  = '0;
            fc_d = fc_q + 16'd1;
          end else begin
            v_d = v_q + 10'd1;
          end
        end else begin
          h_d = h_q + 10'd1;
        end
      end
      hs_d = (hx >= HSyncStart && hx < HSyncEnd) ? SYNC_POL : !SYNC_POL;
      vs_d = (vx >= VSyncStart && vx < VSyncEnd) ? SYNC_POL : !SYNC_POL;
      vo_d = (hx < HVis) && (vx < VVis);
      fs_d = (h_d == '0) && (v_d == '0);
      le_d = (hx == HVis - 11'd1) && (vx < VVis);
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      h_q   <= '0;
      v_q   <= '0;
      fc_q  <= '0;
      run_q <= 1'b0;
      hs_q  <= !SYNC_POL;
      vs_q  <= !SYNC_POL;
      vo_q  <= 1'b0;
      fs_q  <= 1'b0;
      le_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      fc_q  <= fc_d;
      run_q <= run_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vo_q  <= vo_d;
      fs_q  <= fs_d;
      le_q  <= le_d;
    end
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = vo_q;
  assign frame_start = fs_q;
  assign line_end    = le_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster (25x13) with a queued reference
// model; frame_count wrap is reached by forcing the counter near its top.
module tb_vga_timing_gen;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;  // 25
  localparam int VT = VV + VF + VS + VB;  // 13

  logic        pixel_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  pixel_x, pixel_y;
  logic        hsync, vsync, video_on, frame_start, line_end;
  logic [15:0] frame_count;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .pixel_clk  (pixel_clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .frame_start(frame_start),
    .line_end   (line_end),
    .frame_count(frame_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        vo;
    logic        fs;
    logic        le;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fails = 0;

  int          m_x = 0, m_y = 0;
  logic        m_run = 1'b0;
  logic [15:0] m_fc = '0;
  logic        m_hs = 1'b1, m_vs = 1'b1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one clock of stimulus, queue the model's expectation, then compare after the edge.
  task automatic step(input logic rst_n, input logic en);
    exp_t e;
    reset_n = rst_n;
    enable  = en;
    e = '0;
    if (!rst_n) begin
      m_x = 0; m_y = 0; m_fc = '0; m_run = 1'b0; m_hs = 1'b1; m_vs = 1'b1;
    end else if (en) begin
      if (m_run) begin
        m_x++;
        if (m_x == HT) begin
          m_x = 0;
          m_y++;
          if (m_y == VT) begin
            m_y = 0;
            m_fc++;
          end
        end
      end
      m_run = 1'b1;
      m_hs = !(m_x >= 18 && m_x <= 21);
      m_vs = !(m_y >= 8 && m_y <= 9);
      e.vo = (m_x < HV) && (m_y < VV);
      e.fs = (m_x == 0) && (m_y == 0);
      e.le = (m_x == HV - 1) && (m_y < VV);
    end
    e.x = 10'(m_x); e.y = 10'(m_y); e.hs = m_hs; e.vs = m_vs; e.fc = m_fc;
    sb.push_back(e);
    @(posedge pixel_clk);
    #1;
    e = sb.pop_front();
    check("pixel_x", 16'(pixel_x), 16'(e.x));
    check("pixel_y", 16'(pixel_y), 16'(e.y));
    check("hsync", 16'(hsync), 16'(e.hs));
    check("vsync", 16'(vsync), 16'(e.vs));
    check("video_on", 16'(video_on), 16'(e.vo));
    check("frame_start", 16'(frame_start), 16'(e.fs));
    check("line_end", 16'(line_end), 16'(e.le));
    check("frame_count", frame_count, e.fc);
  endtask

  task automatic run_to(input int x, input int y);
    for (int i = 0; i < 2000; i++) begin
      if (m_x == x && m_y == y) break;
      step(1'b1, 1'b1);
    end
    check("run_to_x", 16'(pixel_x), 16'(x));
    check("run_to_y", 16'(pixel_y), 16'(y));
  endtask

  int hs_low, vs_low, vo_cnt, le_cnt;

  initial begin
    // Reset held for five clocks.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check("rst_x", 16'(pixel_x), 16'd0);
    check("rst_video_on", 16'(video_on), 16'd0);
    check("rst_hsync", 16'(hsync), 16'd1);
    check("rst_vsync", 16'(vsync), 16'd1);

    // First enabled edge shows (0,0) with frame_start.
    step(1'b1, 1'b1);
    check("start_x", 16'(pixel_x), 16'd0);
    check("start_y", 16'(pixel_y), 16'd0);
    check("start_video_on", 16'(video_on), 16'd1);
    check("start_frame_start", 16'(frame_start), 16'd1);

    // Rest of the first frame, tallying observed output activity.
    hs_low = 0; vs_low = 0; vo_cnt = 1; le_cnt = 0;
    for (int i = 1; i < HT * VT; i++) begin
      step(1'b1, 1'b1);
      if (pixel_y == 10'd0 && !hsync) hs_low++;
      if (!vsync) vs_low++;
      if (video_on) vo_cnt++;
      if (line_end) le_cnt++;
    end
    check("last_x", 16'(pixel_x), 16'(HT - 1));
    check("last_y", 16'(pixel_y), 16'(VT - 1));
    check("hsync_low_line0", 16'(hs_low), 16'(HS));
    check("vsync_low_frame", 16'(vs_low), 16'(VS * HT));
    check("video_on_count", 16'(vo_cnt), 16'(HV * VV));
    check("line_end_count", 16'(le_cnt), 16'(VV));
    step(1'b1, 1'b1);
    check("wrap_frame_start", 16'(frame_start), 16'd1);
    check("wrap_frame_count", frame_count, 16'd1);

    // Hold with enable low mid-line, then resume.
    run_to(10, 3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("hold_x", 16'(pixel_x), 16'd10);
    check("hold_video_on", 16'(video_on), 16'd0);
    step(1'b1, 1'b1);
    check("resume_x", 16'(pixel_x), 16'd11);

    // Single-cycle reset deep in the frame (horizontal sync region).
    run_to(20, 4);
    check("pre_rst_hsync", 16'(hsync), 16'd0);
    step(1'b0, 1'b1);
    check("midrst_x", 16'(pixel_x), 16'd0);
    check("midrst_hsync", 16'(hsync), 16'd1);
    check("midrst_fc", frame_count, 16'd0);
    step(1'b1, 1'b1);
    check("midrst_frame_start", 16'(frame_start), 16'd1);

    // frame_count wrap: preload 16'hFFFF through a force, then finish the frame.
    run_to(5, 2);
    force dut.fc_q = 16'hFFFF;
    m_fc = 16'hFFFF;
    #1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    release dut.fc_q;
    run_to(HT - 1, VT - 1);
    check("pre_wrap_fc", frame_count, 16'hFFFF);
    step(1'b1, 1'b1);
    check("fc_wrap", frame_count, 16'h0000);
    check("fc_wrap_frame_start", 16'(frame_start), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
